// File: rtl/lzc_norm_pkg.sv
// Shared constants and helpers for the leading-zero/leading-one normaliser.
// The mode constants select which bit value is being counted from the MSB.
package lzc_norm_pkg;

  localparam logic MODE_LZ = 1'b0;
  localparam logic MODE_LO = 1'b1;

  // Smallest power of two that is greater than or equal to w (w >= 1).
  function automatic int next_pow2(input int w);
    int p;
    p = 1;
    while (p < w) begin
      p = p * 2;
    end
    return p;
  endfunction

endpackage

// File: rtl/lzc_norm_pipe_tree.sv
// Purely combinational recursive leading-zero counter over a power-of-two word
// of 2**(CW-1) bits. An all-zero input saturates the count at 2**(CW-1), which
// is the only value with the count MSB set, so a parent can detect an empty
// half from that single bit.
module lzc_tree #(
  parameter int CW = 2
) (
  input  logic [(2**(CW-1))-1:0] data_i,
  output logic [CW-1:0]          count_o
);

  localparam int N = 2**(CW-1);

  generate
    if (CW == 1) begin : g_leaf
      assign count_o = ~data_i;
    end else begin : g_node
      logic [CW-2:0] hi_count;
      logic [CW-2:0] lo_count;

      lzc_tree #(.CW(CW-1)) u_hi (
        .data_i  (data_i[N-1:N/2]),
        .count_o (hi_count)
      );

      lzc_tree #(.CW(CW-1)) u_lo (
        .data_i  (data_i[N/2-1:0]),
        .count_o (lo_count)
      );

      // Upper half empty: add the lower half's count on top of N/2.
      assign count_o = hi_count[CW-2] ? ({1'b0, hi_count} + {1'b0, lo_count})
                                      : {1'b0, hi_count};
    end
  endgenerate

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage valid/ready leading-zero / leading-one counter with an optional
// normalising left shift. S1 registers the (possibly inverted) operand, S2
// registers the count, all-flag, normalised word and tag.
// Build option: define LZC_NORM_PIPE_SHIFT_EN to build the normalising
// shifter and its raw-data register; otherwise out_norm is tied to zero.
module lzc_norm_pipe
  import lzc_norm_pkg::*;
#(
  parameter int  WIDTH = 24,
  parameter int  TAG_W = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW  = next_pow2(WIDTH);
  localparam int TCW = $clog2(PW) + 1;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_word_q;
  logic [WIDTH-1:0] s1_word_d;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [CW-1:0]    s2_count_q;
  logic [CW-1:0]    s2_count_d;
  logic             s2_all_q;
  logic             s2_all_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [PW-1:0]    padded_word;
  logic [TCW-1:0]   tree_count;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Inverting in LO mode lets the tree always count zeros.
  assign s1_word_d = (in_mode == MODE_LO) ? ~in_data : in_data;

  // S1: capture the operand and tag whenever the stage is free to move.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_word_q <= s1_word_d;
        s1_tag_q  <= in_tag;
      end
    end
  end

  // Padding the LSB side with ones stops the scan at WIDTH for a zero word.
  generate
    if (PW > WIDTH) begin : g_pad
      assign padded_word = {s1_word_q, {(PW-WIDTH){1'b1}}};
    end else begin : g_nopad
      assign padded_word = s1_word_q;
    end
  endgenerate

  lzc_tree #(.CW(TCW)) u_tree (
    .data_i  (padded_word),
    .count_o (tree_count)
  );

  assign s2_count_d = tree_count[CW-1:0];
  assign s2_all_d   = (tree_count == TCW'(WIDTH));

  // S2: register the count result; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_count_q <= '0;
      s2_all_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_count_q <= s2_count_d;
        s2_all_q   <= s2_all_d;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

`ifdef LZC_NORM_PIPE_SHIFT_EN
  logic [WIDTH-1:0] s1_raw_q;
  logic [WIDTH-1:0] s2_norm_q;
  logic [WIDTH-1:0] s2_norm_d;

  // Shifting the raw word by the full width zero-fills it, giving 0 at count == WIDTH.
  assign s2_norm_d = s1_raw_q << s2_count_d;

  // S1 raw operand, kept uninverted so the normalised word is the true data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_raw_q <= '0;
    end else if (s1_adv && in_valid) begin
      s1_raw_q <= in_data;
    end
  end

  // S2 normalised word, advancing in lockstep with the count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_norm_q <= '0;
    end else if (s2_adv && s1_valid_q) begin
      s2_norm_q <= s2_norm_d;
    end
  end

  assign out_norm = s2_norm_q;
`else
  assign out_norm = '0;
`endif

  assign out_valid = s2_valid_q;
  assign out_count = s2_count_q;
  assign out_all   = s2_all_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed and randomised checks for lzc_norm_pipe at WIDTH=24, TAG_W=4.
// Expected results come from hand-computed vectors and a bit-scan model.
module tb_lzc_norm_pipe;
  import lzc_norm_pkg::*;

  localparam int WIDTH = 24;
  localparam int TAG_W = 4;
  localparam int CW    = 5;

  typedef struct {
    logic [CW-1:0]    count;
    logic             all;
    logic [WIDTH-1:0] norm;
    logic [TAG_W-1:0] tag;
    logic             lat;
    int               accCycle;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             m;
    logic [CW-1:0]    c;
    logic             a;
    logic [WIDTH-1:0] n;
  } dir_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = MODE_LZ;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_count;
  logic             out_all;
  logic [WIDTH-1:0] out_norm;
  logic [TAG_W-1:0] out_tag;

  int   numChecks = 0;
  int   numErrors = 0;
  int   cycleNo   = 0;
  exp_t expQ[$];

  always #5 clk = ~clk;

  lzc_norm_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_all   (out_all),
    .out_norm  (out_norm),
    .out_tag   (out_tag)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  // Bit-scan reference: count leading bits equal to the target bit.
  function automatic exp_t refModel(input logic [WIDTH-1:0] d, input logic m,
                                    input logic [TAG_W-1:0] t, input logic lat);
    exp_t e;
    int   c;
    c = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i] != m) break;
      c++;
    end
    e.count    = CW'(c);
    e.all      = (c == WIDTH);
    e.norm     = (c == WIDTH) ? '0 : (d << c);
    e.tag      = t;
    e.lat      = lat;
    e.accCycle = 0;
    return e;
  endfunction

  function automatic dir_t getDir(input int i);
    dir_t v;
    case (i)
      0:  v = '{24'h008000, MODE_LZ, 5'd8,  1'b0, 24'h800000};
      1:  v = '{24'h000000, MODE_LZ, 5'd24, 1'b1, 24'h000000};
      2:  v = '{24'hF00000, MODE_LO, 5'd4,  1'b0, 24'h000000};
      3:  v = '{24'hFFFFFF, MODE_LO, 5'd24, 1'b1, 24'h000000};
      4:  v = '{24'h800000, MODE_LZ, 5'd0,  1'b0, 24'h800000};
      5:  v = '{24'h7FFFFF, MODE_LO, 5'd0,  1'b0, 24'h7FFFFF};
      6:  v = '{24'h000001, MODE_LZ, 5'd23, 1'b0, 24'h800000};
      7:  v = '{24'hFFFFFE, MODE_LO, 5'd23, 1'b0, 24'h000000};
      8:  v = '{24'hFFFFFF, MODE_LZ, 5'd0,  1'b0, 24'hFFFFFF};
      9:  v = '{24'h000000, MODE_LO, 5'd0,  1'b0, 24'h000000};
      10: v = '{24'h123456, MODE_LZ, 5'd3,  1'b0, 24'h91A2B0};
      default: v = '{24'hC30000, MODE_LO, 5'd2, 1'b0, 24'h0C0000};
    endcase
    return v;
  endfunction

  // One clock cycle: drive inputs, sample handshakes mid-cycle, score outputs.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic m,
                               input logic [TAG_W-1:0] t, input logic ordy,
                               input exp_t e, output logic acc);
    logic outTx;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = ordy;
    #1;
    acc   = in_valid && in_ready;
    outTx = out_valid && out_ready;
    if (outTx) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedBeat", 32'(out_valid), 32'(0));
      end else begin
        exp_t x;
        x = expQ.pop_front();
        checkOutput("count", 32'(out_count), 32'(x.count));
        checkOutput("all", 32'(out_all), 32'(x.all));
`ifdef LZC_NORM_PIPE_SHIFT_EN
        checkOutput("norm", 32'(out_norm), 32'(x.norm));
`else
        checkOutput("norm", 32'(out_norm), 32'(0));
`endif
        checkOutput("tag", 32'(out_tag), 32'(x.tag));
        if (x.lat) checkOutput("latency", 32'(cycleNo - x.accCycle), 32'd2);
      end
    end
    if (acc) begin
      e.accCycle = cycleNo;
      expQ.push_back(e);
    end
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic drainPipe();
    logic acc;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      applyStimulus(1'b0, '0, MODE_LZ, '0, 1'b1, refModel('0, MODE_LZ, '0, 1'b0), acc);
    end
    checkOutput("drainLeft", 32'(expQ.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic             acc;
    logic [WIDTH-1:0] rd;
    logic             rm;
    logic             pending;
    dir_t             dv;
    int               k;
    int               sent;
    logic [CW-1:0]    snapCount;
    logic [TAG_W-1:0] snapTag;
    logic             snapValid;

    // Reset and check the idle state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstValid", 32'(out_valid), 32'(0));
    checkOutput("rstReady", 32'(in_ready), 32'(1));
    checkOutput("rstCount", 32'(out_count), 32'(0));
    checkOutput("rstAll", 32'(out_all), 32'(0));
    checkOutput("rstNorm", 32'(out_norm), 32'(0));
    checkOutput("rstTag", 32'(out_tag), 32'(0));
    @(negedge clk);

    // Directed vectors back to back, modes interleaved, latency checked.
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      dv = getDir(i);
      e.count = dv.c; e.all = dv.a; e.norm = dv.n; e.tag = TAG_W'(i); e.lat = 1'b1; e.accCycle = 0;
      applyStimulus(1'b1, dv.d, dv.m, TAG_W'(i), 1'b1, e, acc);
      checkOutput("dirAccept", 32'(acc), 32'(1));
    end
    drainPipe();

    // Stall: downstream blocked for 5 cycles with a steady source.
    k = 0;
    snapCount = '0; snapTag = '0; snapValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd = 24'h00F000 >> k;
      applyStimulus(1'b1, rd, MODE_LZ, TAG_W'(8 + k), 1'b0, refModel(rd, MODE_LZ, TAG_W'(8 + k), 1'b0), acc);
      if (acc) k++;
      if (i == 1) begin
        snapCount = out_count; snapTag = out_tag; snapValid = out_valid;
        checkOutput("stallValid", 32'(snapValid), 32'(1));
      end else if (i > 1) begin
        checkOutput("stallCount", 32'(out_count), 32'(snapCount));
        checkOutput("stallTag", 32'(out_tag), 32'(snapTag));
        checkOutput("stallHold", 32'(out_valid), 32'(snapValid));
      end
    end
    checkOutput("stallAccepted", 32'(k), 32'(2));
    checkOutput("stallInReady", 32'(in_ready), 32'(0));
    for (int i = 0; i < 20 && k < 5; i++) begin
      rd = 24'h00F000 >> k;
      applyStimulus(1'b1, rd, MODE_LZ, TAG_W'(8 + k), 1'b1, refModel(rd, MODE_LZ, TAG_W'(8 + k), 1'b0), acc);
      if (acc) k++;
    end
    checkOutput("stallSent", 32'(k), 32'(5));
    drainPipe();

    // Reset with two beats in flight; neither may emerge afterwards.
    applyStimulus(1'b1, 24'h000F00, MODE_LZ, 4'hA, 1'b0, refModel(24'h000F00, MODE_LZ, 4'hA, 1'b0), acc);
    applyStimulus(1'b1, 24'hFF0000, MODE_LO, 4'hB, 1'b0, refModel(24'hFF0000, MODE_LO, 4'hB, 1'b0), acc);
    rst = 1'b1; in_valid = 1'b1; in_data = 24'h000003; in_mode = MODE_LZ; in_tag = 4'hC; out_ready = 1'b1;
    @(negedge clk);
    cycleNo++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(out_valid), 32'(0));
    checkOutput("midRstReady", 32'(in_ready), 32'(1));
    expQ.delete();
    @(negedge clk);
    cycleNo++;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, MODE_LZ, '0, 1'b1, refModel('0, MODE_LZ, '0, 1'b0), acc);
    end
    applyStimulus(1'b1, 24'h0000FF, MODE_LZ, 4'h5, 1'b1, refModel(24'h0000FF, MODE_LZ, 4'h5, 1'b0), acc);
    drainPipe();

    // Random valid/ready against the bit-scan model.
    sent = 0; pending = 1'b0; rd = '0; rm = MODE_LZ;
    for (int i = 0; i < 3000 && sent < 300; i++) begin
      if (!pending) begin
        rd = 24'($urandom);
        rd = rd >> $urandom_range(0, 24);
        rm = 1'($urandom_range(0, 1));
        if (rm == MODE_LO) rd = ~rd;
        pending = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 9) < 7), rd, rm, TAG_W'(sent),
                    1'($urandom_range(0, 9) < 7), refModel(rd, rm, TAG_W'(sent), 1'b0), acc);
      if (acc) begin
        sent++;
        pending = 1'b0;
      end
    end
    checkOutput("randSent", 32'(sent), 32'(300));
    drainPipe();

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
# lzc_norm_pipe

Pipelined, handshaked leading-zero/leading-one counter with optional normalising left shift for arbitrary (non power-of-two) operand widths. It sits in the ROSETTA datapath after accumulation, ahead of the exponent-adjust/rounding logic. The block streams one operand per cycle under valid/ready flow control and carries a sideband tag alongside each operand.

## Interface
- WIDTH, 24: operand width; any value ≥ 2, not restricted to powers of two.
- TAG_W, 4: sideband tag width; must be ≥ 1.
- CW, derived: $clog2(WIDTH+1); count width; not overridable.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  the input beat is valid.
- in_ready  out  1  the block accepts a beat this cycle.
- in_data  in  WIDTH  operand.
- in_mode  in  1  0 = count leading zeros (LZ); 1 = count leading ones (LO).
- in_tag  in  TAG_W  sideband; passed through unchanged.
- out_valid  out  1  the result beat is valid.
- out_ready  in  1  downstream accepts the result.
- out_count  out  CW  number of leading bits equal to the target bit (0 for LZ, 1 for LO); range 0..WIDTH.
- out_all  out  1  every bit equals the target bit (out_count == WIDTH).
- out_norm  out  WIDTH  in_data << out_count, zero-filled (present only with the macro; see Configuration).
- out_tag  out  TAG_W  tag of this beat.

## Operation
- A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Stage S1 registers the operand. In LO mode it registers ~in_data, so the downstream tree always counts zeros. It also registers the tag, mode, raw data and a valid bit.
- Stage S2 computes the count from the S1 register using the combinational tree, then registers count, all-flag, norm, tag and valid.
- Count: index of the first 1 scanning from the MSB of the (possibly inverted) word. An all-zero word gives count = WIDTH and out_all = 1.
- Non power-of-two WIDTH: the word is padded on the LSB side with 1s to the next power of two. This guarantees count ≤ WIDTH.
- Norm: the raw (non-inverted) data is shifted left by count, with zeros shifted in. When count == WIDTH, norm = 0.
  - In LZ mode with a non-zero operand, norm[WIDTH-1] = 1.
  - In LO mode, norm[WIDTH-1] = 0 unless count == WIDTH.
- Flow control:
  - S2 advances when !S2.valid || out_ready.
  - S1 advances when !S1.valid || S2 advances.
  - in_ready = !S1.valid || S2 advances.
- Bubbles collapse; throughput is one beat per cycle when out_ready is held high.
- While out_valid && !out_ready, all out_* outputs hold stable. No beat is dropped or duplicated.

## Timing
- Latency: 2 cycles from input transfer to out_valid, when there are no stalls.
- in_ready depends combinationally on out_ready, through one AND/OR level only. There is no combinational path from in_* to out_*.
- Reset: S1.valid = 0 and S2.valid = 0. Therefore out_valid = 0 and in_ready = 1 in the first cycle after reset.
  - out_count, out_all, out_norm and out_tag reset to 0.
- Reset asserted mid-stream discards all in-flight beats on the next edge. A beat presented in the same cycle as rst is not accepted.
- Simultaneous output transfer and input transfer in the same cycle is legal at full occupancy; the pipeline shifts by one.
- Mode is sampled per beat. Interleaving LZ and LO beats requires no idle cycle.

## Configuration
- LZC_NORM_PIPE_SHIFT_EN:
  - Defined: the normalising shifter is built and out_norm is driven as specified.
  - Undefined: the shifter and the S1 raw-data register are removed, and out_norm is tied to 0.
  - Count, flag, tag and handshake behaviour are identical in both builds.

## Structure
- Package lzc_norm_pkg holds:
  - mode constants MODE_LZ = 1'b0 and MODE_LO = 1'b1;
  - a constant function returning the next power of two ≥ WIDTH.
- One sub-module, lzc_tree: a purely combinational, recursive, power-of-two leading-zero tree.
  - Parameter: CW.
  - Output: count, saturating at 2^(CW-1) for an all-zero input.
  - lzc_norm_pipe instantiates it once on the padded word.

## Test plan
- Default parameters, out_ready = 1, LZ mode:
  - in_data 24'h00_8000 → count 8, all 0, norm 24'h80_0000.
  - in_data 24'h0 → count 24, all 1, norm 0.
  - Each result appears 2 cycles after acceptance.
- LO mode:
  - in_data 24'hF0_0000 → count 4, norm 24'h00_0000.
  - in_data 24'hFF_FFFF → count 24, all 1.
  - Alternate LO and LZ beats back to back; every result matches mode and tag.
- WIDTH = 5, all 32 operands in both modes → count equals a behavioural scan, never exceeds 5.
- Stall: hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready drops after 2 beats are accepted; out_* stays stable; tags emerge in order with no loss when out_ready is raised.
- Random valid/ready, 10k beats → output sequence equals the reference model in order.
- Assert rst with 2 beats in flight → out_valid = 0 on the next cycle and the in-flight beats never appear.
- Build without LZC_NORM_PIPE_SHIFT_EN → out_norm is 0 and counts match the shifted build.
